dsipo_rx: RTL

DSIPO_RX -- requirements
Module: dsipo_rx

---
 rtl/dsipo_pkg.sv | 15 +
 rtl/sipo_shift_reg.sv | 51 +++++
 rtl/dsipo_rx.sv | 136 +++++++++++++
 3 files changed

// File: rtl/dsipo_pkg.sv
// Shared definitions for the dsipo_rx serial-to-parallel receiver.
//   state_e   : receiver FSM states (idle / shifting a frame)
//   cnt_width : bit-counter width needed to count 0..width
package dsipo_pkg;

  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StShift = 1'b1
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/sipo_shift_reg.sv
// Bit-capture datapath for dsipo_rx.
// Ports:
//   clk        : clock, rising edge
//   reset      : asynchronous, active-high; clears the register
//   clear      : synchronous clear of the stored bits (after a completed word)
//   load_first : capture sin as bit 0 of a new word, dropping any partial word
//   shift      : capture sin into the next bit position
//   sin        : serial data bit
//   word       : stored bits with this edge's capture already applied, so a
//                word completing on this edge is visible without a cycle delay
module sipo_shift_reg
  import dsipo_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load_first,
  input  logic             shift,
  input  logic             sin,
  output logic [WIDTH-1:0] word
);

  logic [WIDTH-1:0] data_q;

  // MSB-first shifts left so bit 0 ends in the top slot; LSB-first shifts
  // right from the top so bit 0 ends in pout[0] after WIDTH captures.
  always_comb begin
    word = data_q;
    if (load_first) begin
      if (MSB_FIRST) word = {{(WIDTH-1){1'b0}}, sin};
      else           word = {sin, {(WIDTH-1){1'b0}}};
    end else if (shift) begin
      if (MSB_FIRST) word = {data_q[WIDTH-2:0], sin};
      else           word = {sin, data_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
    end else if (clear) begin
      data_q <= '0;
    end else if (load_first || shift) begin
      data_q <= word;
    end
  end

endmodule

// File: rtl/dsipo_rx.sv
// Framed serial-to-parallel receiver with a one-word output register.
// Ports:
//   clk        : clock, rising edge
//   reset      : asynchronous, active-high
//   sin        : serial data bit
//   sin_valid  : sin is sampled on this edge
//   sof        : start of frame, marks sin as bit 0 (qualified by sin_valid)
//   pout       : assembled parallel word
//   pout_valid : pout holds an unconsumed word
//   pout_ready : consumer accepts pout when high with pout_valid
//   busy       : a frame is partially received
//   overrun    : sticky, a completed word was dropped
//   clr_ovr    : synchronous clear of overrun
module dsipo_rx
  import dsipo_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             sof,
  output logic [WIDTH-1:0] pout,
  output logic             pout_valid,
  input  logic             pout_ready,
  output logic             busy,
  output logic             overrun,
  input  logic             clr_ovr
);

  localparam int unsigned     CntW    = cnt_width(WIDTH);
  localparam logic [CntW-1:0] LastIdx = CntW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] pout_q, pout_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;

  logic             load_first, shift, complete, drop;
  logic [WIDTH-1:0] word;

  sipo_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift (
    .clk        (clk),
    .reset      (reset),
    .clear      (complete),
    .load_first (load_first),
    .shift      (shift),
    .sin        (sin),
    .word       (word)
  );

  // Frame FSM. A sof always restarts the word, even mid-frame.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    load_first = 1'b0;
    shift      = 1'b0;
    complete   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (sin_valid && sof) begin
          load_first = 1'b1;
          cnt_d      = CntW'(1);
          state_d    = StShift;
        end
      end
      StShift: begin
        if (sin_valid) begin
          if (sof) begin
            load_first = 1'b1;
            cnt_d      = CntW'(1);
          end else if (cnt_q == LastIdx) begin
            shift    = 1'b1;
            complete = 1'b1;
            cnt_d    = '0;
            state_d  = StIdle;
          end else begin
            shift = 1'b1;
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Output register: a word completing while the held one is not being taken
  // is dropped and flagged; the held word is never overwritten.
  assign drop = complete && valid_q && !pout_ready;

  always_comb begin
    pout_d  = pout_q;
    valid_d = valid_q;
    if (complete && (!valid_q || pout_ready)) begin
      pout_d  = word;
      valid_d = 1'b1;
    end else if (valid_q && pout_ready) begin
      valid_d = 1'b0;
    end
    // Set wins over clear on the same edge.
    if (drop)         ovr_d = 1'b1;
    else if (clr_ovr) ovr_d = 1'b0;
    else              ovr_d = ovr_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      pout_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pout_q  <= pout_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign pout       = pout_q;
  assign pout_valid = valid_q;
  assign busy       = (state_q == StShift);
  assign overrun    = ovr_q;

endmodule
